// File: rtl/sniffer_pkg.sv
// rtl/sniffer_pkg.sv - shared types and defaults for the packet hit tracker
package sniffer_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

endpackage

// File: rtl/packet_hit_tracker_if.sv
// rtl/packet_hit_tracker_if.sv - packet beat bus from the field matchers
interface packet_hit_tracker_if
    import sniffer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);
    logic              valid;
    logic              sop;
    logic              eop;
    logic [5:0]        error;
    logic [NUM_CH-1:0] match_vec;

    modport master (output valid, sop, eop, error, match_vec);
    modport slave  (input  valid, sop, eop, error, match_vec);
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_hit_tracker.sv
// rtl/packet_hit_tracker.sv - per-packet match accumulation with commit/drop counters
module packet_hit_tracker
    import sniffer_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int RD_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    packet_hit_tracker_if.slave           pkt,
    input  logic                          clear_counts,
    input  logic [RD_W-1:0]               rd_sel,
    output logic [NUM_CH-1:0][CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]              rd_count,
    output logic [CNT_W-1:0]              pkt_count,
    output logic [CNT_W-1:0]              drop_count,
    output logic                          commit,
    output logic                          busy
);

    state_t            state, state_nx;
    logic [NUM_CH-1:0] pending, pending_nx, acc_vec, hit_inc;
    logic              good_end, drop_inc, err_any, in_pkt;
    logic [CNT_W-1:0]  rd_mux;

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        good_end   = 1'b0;
        drop_inc   = 1'b0;
        err_any    = |pkt.error;
        in_pkt     = pkt.sop || (state == ST_ACTIVE);
        acc_vec    = pkt.sop ? pkt.match_vec : (pending | pkt.match_vec);
        if (pkt.valid && in_pkt) begin
            // A sop restarts the packet; an unfinished ACTIVE one is lost.
            drop_inc = pkt.sop && (state == ST_ACTIVE);
            if (pkt.eop) begin
                state_nx   = ST_IDLE;
                pending_nx = '0;
                if (err_any) drop_inc = 1'b1;
                else         good_end = 1'b1;
            end else if (err_any) begin
                state_nx   = ST_ABORT;
                pending_nx = '0;
            end else begin
                state_nx   = ST_ACTIVE;
                pending_nx = acc_vec;
            end
        end else if (pkt.valid && (state == ST_ABORT) && pkt.eop) begin
            state_nx = ST_IDLE;
            drop_inc = 1'b1;
        end
        hit_inc = good_end ? acc_vec : '0;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == RD_W'(i)) rd_mux = hit_count[i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            pending  <= '0;
            commit   <= 1'b0;
            rd_count <= '0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            commit   <= good_end;
            rd_count <= rd_mux;
        end
    end

    assign busy = (state != ST_IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
        sat_counter #(.CNT_W(CNT_W)) u_hit (
            .clk   (clk),
            .n_rst (n_rst),
            .inc   (hit_inc[g]),
            .clr   (clear_counts),
            .count (hit_count[g])
        );
    end

    sat_counter #(.CNT_W(CNT_W)) u_pkt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (good_end),
        .clr   (clear_counts),
        .count (pkt_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (drop_inc),
        .clr   (clear_counts),
        .count (drop_count)
    );

endmodule

// File: tb/tb_packet_hit_tracker.sv
// tb/tb_packet_hit_tracker.sv - directed self-checking bench for packet_hit_tracker
module tb_packet_hit_tracker;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        valid, sop, eop, clear_counts;
    logic [5:0]  error;
    logic [3:0]  match_vec;
    logic [1:0]  rd_sel;

    logic [3:0][31:0] hit_count;
    logic [31:0]      rd_count, pkt_count, drop_count;
    logic             commit, busy;

    logic [2:0][7:0]  hit_count8;
    logic [7:0]       rd_count8, pkt_count8, drop_count8;
    logic             commit8, busy8;

    int n_checks = 0;
    int n_errors = 0;

    packet_hit_tracker_if #(.NUM_CH(4)) pif ();
    packet_hit_tracker_if #(.NUM_CH(3)) pif8 ();

    assign pif.valid      = valid;
    assign pif.sop        = sop;
    assign pif.eop        = eop;
    assign pif.error      = error;
    assign pif.match_vec  = match_vec;
    assign pif8.valid     = valid;
    assign pif8.sop       = sop;
    assign pif8.eop       = eop;
    assign pif8.error     = error;
    assign pif8.match_vec = match_vec[2:0];

    packet_hit_tracker #(.NUM_CH(4), .CNT_W(32)) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pkt          (pif),
        .clear_counts (clear_counts),
        .rd_sel       (rd_sel),
        .hit_count    (hit_count),
        .rd_count     (rd_count),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count),
        .commit       (commit),
        .busy         (busy)
    );

    packet_hit_tracker #(.NUM_CH(3), .CNT_W(8)) u_dut8 (
        .clk          (clk),
        .n_rst        (n_rst),
        .pkt          (pif8),
        .clear_counts (clear_counts),
        .rd_sel       (rd_sel),
        .hit_count    (hit_count8),
        .rd_count     (rd_count8),
        .pkt_count    (pkt_count8),
        .drop_count   (drop_count8),
        .commit       (commit8),
        .busy         (busy8)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic s, input logic e, input logic [5:0] err, input logic [3:0] mv);
        valid = 1'b1; sop = s; eop = e; error = err; match_vec = mv;
        @(posedge clk); #1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0; match_vec = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        n_rst = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0;
        match_vec = '0; clear_counts = 1'b0; rd_sel = '0;
        repeat (2) tick();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_commit", {31'd0, commit}, 32'd0);
        check_eq("rst_pkt", pkt_count, 32'd0);
        check_eq("rst_drop", drop_count, 32'd0);
        check_eq("rst_hit0", hit_count[0], 32'd0);
        n_rst = 1'b1;
        tick();

        // Good packet: MAC and port mid-packet
        beat(1'b1, 1'b0, 6'h00, 4'b0000);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        beat(1'b0, 1'b0, 6'h00, 4'b0001);
        beat(1'b0, 1'b0, 6'h00, 4'b0100);
        check_eq("t1_no_early_commit", {31'd0, commit}, 32'd0);
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        check_eq("t1_commit", {31'd0, commit}, 32'd1);
        check_eq("t1_hit0", hit_count[0], 32'd1);
        check_eq("t1_hit1", hit_count[1], 32'd0);
        check_eq("t1_hit2", hit_count[2], 32'd1);
        check_eq("t1_hit3", hit_count[3], 32'd0);
        check_eq("t1_pkt", pkt_count, 32'd1);
        check_eq("t1_idle", {31'd0, busy}, 32'd0);
        rd_sel = 2'd2;
        tick();
        check_eq("t1_commit_pulse", {31'd0, commit}, 32'd0);
        check_eq("t1_rd2", rd_count, 32'd1);

        // Errored packet, URL match after the error
        beat(1'b1, 1'b0, 6'h00, 4'b0000);
        beat(1'b0, 1'b0, 6'h3F, 4'b0000);
        check_eq("t2_abort_busy", {31'd0, busy}, 32'd1);
        beat(1'b0, 1'b0, 6'h00, 4'b1000);
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        check_eq("t2_commit", {31'd0, commit}, 32'd0);
        check_eq("t2_drop", drop_count, 32'd1);
        check_eq("t2_hit3", hit_count[3], 32'd0);
        check_eq("t2_pkt", pkt_count, 32'd1);
        tick();
        check_eq("t2_commit_after", {31'd0, commit}, 32'd0);

        // IP on three beats counts once
        beat(1'b1, 1'b0, 6'h00, 4'b0010);
        beat(1'b0, 1'b0, 6'h00, 4'b0010);
        beat(1'b0, 1'b1, 6'h00, 4'b0010);
        check_eq("t3_hit1", hit_count[1], 32'd1);
        check_eq("t3_pkt", pkt_count, 32'd2);

        // Single-beat packets: good, then errored on the eop beat
        beat(1'b1, 1'b1, 6'h00, 4'b1000);
        check_eq("t4_commit", {31'd0, commit}, 32'd1);
        check_eq("t4_hit3", hit_count[3], 32'd1);
        check_eq("t4_pkt", pkt_count, 32'd3);
        beat(1'b1, 1'b1, 6'h01, 4'b0001);
        check_eq("t4_err_commit", {31'd0, commit}, 32'd0);
        check_eq("t4_drop", drop_count, 32'd2);
        check_eq("t4_hit0", hit_count[0], 32'd1);

        // sop while ACTIVE drops the first packet
        beat(1'b1, 1'b0, 6'h00, 4'b0001);
        beat(1'b1, 1'b0, 6'h00, 4'b0100);
        check_eq("t5_drop", drop_count, 32'd3);
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        check_eq("t5_pkt", pkt_count, 32'd4);
        check_eq("t5_hit0", hit_count[0], 32'd1);
        check_eq("t5_hit2", hit_count[2], 32'd2);

        // sop while ABORT starts a new packet without another drop
        beat(1'b1, 1'b0, 6'h00, 4'b0000);
        beat(1'b0, 1'b0, 6'h20, 4'b0000);
        beat(1'b1, 1'b0, 6'h00, 4'b0010);
        check_eq("t6_drop", drop_count, 32'd3);
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        check_eq("t6_hit1", hit_count[1], 32'd2);
        check_eq("t6_pkt", pkt_count, 32'd5);

        // clear_counts on the commit cycle, then on the eop beat itself
        beat(1'b1, 1'b0, 6'h00, 4'b0001);
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        check_eq("t7_hit0_pre", hit_count[0], 32'd2);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        check_eq("t7_hit0", hit_count[0], 32'd0);
        check_eq("t7_hit2", hit_count[2], 32'd0);
        check_eq("t7_pkt", pkt_count, 32'd0);
        check_eq("t7_drop", drop_count, 32'd0);
        beat(1'b1, 1'b0, 6'h00, 4'b0001);
        clear_counts = 1'b1;
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        clear_counts = 1'b0;
        check_eq("t7_clr_wins_hit0", hit_count[0], 32'd0);
        check_eq("t7_clr_wins_pkt", pkt_count, 32'd0);
        check_eq("t7_clr_commit", {31'd0, commit}, 32'd1);

        // Reset mid-packet discards silently
        beat(1'b1, 1'b0, 6'h00, 4'b0001);
        check_eq("t8_busy_pre", {31'd0, busy}, 32'd1);
        #2 n_rst = 1'b0;
        #1 check_eq("t8_async_busy", {31'd0, busy}, 32'd0);
        tick();
        n_rst = 1'b1;
        beat(1'b0, 1'b1, 6'h00, 4'b0000);
        check_eq("t8_drop", drop_count, 32'd0);
        check_eq("t8_pkt", pkt_count, 32'd0);
        check_eq("t8_commit", {31'd0, commit}, 32'd0);

        // 8-bit counters saturate
        for (int i = 0; i < 260; i++) beat(1'b1, 1'b1, 6'h00, 4'b0001);
        check_eq("t9_hit0_sat", {24'd0, hit_count8[0]}, 32'd255);
        check_eq("t9_pkt_sat", {24'd0, pkt_count8}, 32'd255);
        check_eq("t9_drop", {24'd0, drop_count8}, 32'd0);
        check_eq("t9_wide_pkt", pkt_count, 32'd260);
        rd_sel = 2'd3;
        tick();
        check_eq("t9_rd_oob", {24'd0, rd_count8}, 32'd0);
        rd_sel = 2'd0;
        tick();
        check_eq("t9_rd0", {24'd0, rd_count8}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
